// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared defaults and constants for the writeback register file
package wb_regfile_pkg;
    localparam int DSIZE_DEF = 32;
    localparam int ASIZE_DEF = 5;
    localparam int ISIZE_DEF = 32;
    localparam int LINK_REG_DEF = 31;
    localparam int CNT_W_DEF = 16;
    localparam int LINK_INC = 1;
endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: writeback bundle, decode read ports and debug outputs of the register file
interface wb_regfile_if
    import wb_regfile_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF,
    parameter int ISIZE = ISIZE_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             wen_in;
    logic [ASIZE-1:0] w_addr_in;
    logic [DSIZE-1:0] w_data_in;
    logic             jal_in;
    logic [ISIZE-1:0] PC_in;
    logic [ASIZE-1:0] r1_addr;
    logic [ASIZE-1:0] r2_addr;
    logic [DSIZE-1:0] r1_data;
    logic [DSIZE-1:0] r2_data;
    logic             wr_commit;
    logic [CNT_W-1:0] wr_count;
    modport master (
        output wen_in, w_addr_in, w_data_in, jal_in, PC_in, r1_addr, r2_addr,
        input  r1_data, r2_data, wr_commit, wr_count
    );
    modport slave (
        input  wen_in, w_addr_in, w_data_in, jal_in, PC_in, r1_addr, r2_addr,
        output r1_data, r2_data, wr_commit, wr_count
    );
endinterface

// File: rtl/wb_write_select.sv
// wb_write_select: effective write address/data/enable (jal link vs normal, r0 squash)
module wb_write_select
    import wb_regfile_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF,
    parameter int ISIZE = ISIZE_DEF,
    parameter int LINK_REG = LINK_REG_DEF
) (
    input  logic             wen,
    input  logic             jal,
    input  logic [ASIZE-1:0] w_addr,
    input  logic [DSIZE-1:0] w_data,
    input  logic [ISIZE-1:0] pc,
    output logic             eff_en,
    output logic [ASIZE-1:0] eff_addr,
    output logic [DSIZE-1:0] eff_data
);
    logic [ISIZE-1:0] link;
    // link value wraps at PC width before being fitted to the data width
    assign link     = pc + ISIZE'(LINK_INC);
    assign eff_addr = jal ? ASIZE'(LINK_REG) : w_addr;
    assign eff_data = jal ? DSIZE'(link) : w_data;
    assign eff_en   = wen && (eff_addr != '0);
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback-fed register file with two registered read ports and a commit counter
// WB_BYPASS_EN selects write-first reads on collision; default is read-first.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF,
    parameter int ISIZE = ISIZE_DEF,
    parameter int LINK_REG = LINK_REG_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic         clk,
    input logic         rst,
    wb_regfile_if.slave bus
);
`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    logic [DSIZE-1:0] regs [2**ASIZE];
    logic             eff_en;
    logic [ASIZE-1:0] eff_addr;
    logic [DSIZE-1:0] eff_data;
    logic [DSIZE-1:0] r1_next, r2_next;
    wb_write_select #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .ISIZE(ISIZE), .LINK_REG(LINK_REG)
    ) u_sel (
        .wen(bus.wen_in), .jal(bus.jal_in), .w_addr(bus.w_addr_in),
        .w_data(bus.w_data_in), .pc(bus.PC_in),
        .eff_en(eff_en), .eff_addr(eff_addr), .eff_data(eff_data)
    );
    // eff_en already excludes r0, so the bypass can never leak a value onto address 0
    assign r1_next = (BYPASS && eff_en && bus.r1_addr == eff_addr) ? eff_data :
                     (bus.r1_addr == '0) ? '0 : regs[bus.r1_addr];
    assign r2_next = (BYPASS && eff_en && bus.r2_addr == eff_addr) ? eff_data :
                     (bus.r2_addr == '0) ? '0 : regs[bus.r2_addr];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**ASIZE; i++) regs[i] <= '0;
            bus.r1_data   <= '0;
            bus.r2_data   <= '0;
            bus.wr_commit <= 1'b0;
            bus.wr_count  <= '0;
        end else begin
            if (eff_en) regs[eff_addr] <= eff_data;
            bus.r1_data   <= r1_next;
            bus.r2_data   <= r2_next;
            bus.wr_commit <= eff_en;
            bus.wr_count  <= bus.wr_count + CNT_W'(eff_en && bus.wr_count != '1);
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed checks of wb_regfile (counter width 4 to reach saturation quickly)
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    wb_regfile_if #(.CNT_W(4)) bus ();
    wb_regfile #(.CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.wen_in = 1'b0;
        bus.jal_in = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.w_addr_in = '0;
        bus.w_data_in = '0;
        bus.PC_in = '0;
        bus.r1_addr = 5'd5;
        bus.r2_addr = 5'd31;
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (bus.r1_data !== 32'h0) begin n_err++; $display("FAIL reset_r1 got %h exp 0", bus.r1_data); end
        n_cmp++; if (bus.r2_data !== 32'h0) begin n_err++; $display("FAIL reset_r2 got %h exp 0", bus.r2_data); end
        n_cmp++; if (bus.wr_count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", bus.wr_count); end
        n_cmp++; if (bus.wr_commit !== 1'b0) begin n_err++; $display("FAIL reset_commit got %b exp 0", bus.wr_commit); end
    endtask
    task automatic test_write();
        bus.wen_in = 1'b1;
        bus.w_addr_in = 5'd3;
        bus.w_data_in = 32'hDEADBEEF;
        tick();
        n_cmp++; if (bus.wr_commit !== 1'b1) begin n_err++; $display("FAIL write_commit got %b exp 1", bus.wr_commit); end
        idle();
        bus.r1_addr = 5'd3;
        tick();
        n_cmp++; if (bus.r1_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL write_read got %h exp deadbeef", bus.r1_data); end
        n_cmp++; if (bus.wr_commit !== 1'b0) begin n_err++; $display("FAIL write_commit_drop got %b exp 0", bus.wr_commit); end
        n_cmp++; if (bus.wr_count !== 4'd1) begin n_err++; $display("FAIL write_count got %0d exp 1", bus.wr_count); end
    endtask
    task automatic test_jal();
        bus.wen_in = 1'b1;
        bus.jal_in = 1'b1;
        bus.PC_in = 32'h40;
        bus.w_addr_in = 5'd7;
        bus.w_data_in = 32'h1234;
        tick();
        n_cmp++; if (bus.wr_commit !== 1'b1) begin n_err++; $display("FAIL jal_commit got %b exp 1", bus.wr_commit); end
        idle();
        bus.r1_addr = 5'd31;
        bus.r2_addr = 5'd7;
        tick();
        n_cmp++; if (bus.r1_data !== 32'h41) begin n_err++; $display("FAIL jal_link got %h exp 41", bus.r1_data); end
        n_cmp++; if (bus.r2_data !== 32'h0) begin n_err++; $display("FAIL jal_r7 got %h exp 0", bus.r2_data); end
        bus.wen_in = 1'b1;
        bus.jal_in = 1'b1;
        bus.PC_in = 32'hFFFFFFFF;
        tick();
        idle();
        tick();
        n_cmp++; if (bus.r1_data !== 32'h0) begin n_err++; $display("FAIL jal_wrap got %h exp 0", bus.r1_data); end
        bus.jal_in = 1'b1;
        bus.PC_in = 32'h80;
        tick();
        bus.jal_in = 1'b0;
        tick();
        n_cmp++; if (bus.r1_data !== 32'h0) begin n_err++; $display("FAIL jal_no_wen got %h exp 0", bus.r1_data); end
        n_cmp++; if (bus.wr_count !== 4'd3) begin n_err++; $display("FAIL jal_count got %0d exp 3", bus.wr_count); end
    endtask
    task automatic test_r0();
        bus.wen_in = 1'b1;
        bus.w_addr_in = 5'd0;
        bus.w_data_in = 32'hFFFFFFFF;
        bus.r1_addr = 5'd0;
        tick();
        n_cmp++; if (bus.wr_commit !== 1'b0) begin n_err++; $display("FAIL r0_commit got %b exp 0", bus.wr_commit); end
        idle();
        tick();
        n_cmp++; if (bus.r1_data !== 32'h0) begin n_err++; $display("FAIL r0_read got %h exp 0", bus.r1_data); end
        n_cmp++; if (bus.wr_count !== 4'd3) begin n_err++; $display("FAIL r0_count got %0d exp 3", bus.wr_count); end
    endtask
    task automatic test_collision();
        logic [31:0] exp_col;
`ifdef WB_BYPASS_EN
        exp_col = 32'h22;
`else
        exp_col = 32'h11;
`endif
        bus.wen_in = 1'b1;
        bus.w_addr_in = 5'd4;
        bus.w_data_in = 32'h11;
        tick();
        bus.w_data_in = 32'h22;
        bus.r1_addr = 5'd4;
        bus.r2_addr = 5'd4;
        tick();
        n_cmp++; if (bus.r1_data !== exp_col) begin n_err++; $display("FAIL col_r1 got %h exp %h", bus.r1_data, exp_col); end
        n_cmp++; if (bus.r2_data !== exp_col) begin n_err++; $display("FAIL col_r2 got %h exp %h", bus.r2_data, exp_col); end
        idle();
        tick();
        n_cmp++; if (bus.r1_data !== 32'h22) begin n_err++; $display("FAIL col_after got %h exp 22", bus.r1_data); end
        n_cmp++; if (bus.wr_count !== 4'd5) begin n_err++; $display("FAIL col_count got %0d exp 5", bus.wr_count); end
    endtask
    task automatic test_back_to_back();
        bus.wen_in = 1'b1;
        bus.w_addr_in = 5'd1;
        bus.w_data_in = 32'hA;
        tick();
        bus.w_addr_in = 5'd2;
        bus.w_data_in = 32'hB;
        bus.r1_addr = 5'd1;
        tick();
        n_cmp++; if (bus.r1_data !== 32'hA) begin n_err++; $display("FAIL b2b_r1 got %h exp a", bus.r1_data); end
        n_cmp++; if (bus.wr_commit !== 1'b1) begin n_err++; $display("FAIL b2b_commit got %b exp 1", bus.wr_commit); end
        idle();
        bus.r2_addr = 5'd2;
        tick();
        n_cmp++; if (bus.r2_data !== 32'hB) begin n_err++; $display("FAIL b2b_r2 got %h exp b", bus.r2_data); end
        n_cmp++; if (bus.wr_count !== 4'd7) begin n_err++; $display("FAIL b2b_count got %0d exp 7", bus.wr_count); end
    endtask
    task automatic test_saturation();
        for (int i = 0; i < 10; i++) begin
            bus.wen_in = 1'b1;
            bus.w_addr_in = 5'd9;
            bus.w_data_in = 32'(i + 1);
            tick();
        end
        idle();
        tick();
        n_cmp++; if (bus.wr_count !== 4'd15) begin n_err++; $display("FAIL sat_count got %0d exp 15", bus.wr_count); end
        bus.r1_addr = 5'd9;
        tick();
        n_cmp++; if (bus.r1_data !== 32'd10) begin n_err++; $display("FAIL sat_r9 got %h exp a", bus.r1_data); end
        rst = 1'b1;
        bus.wen_in = 1'b1;
        bus.w_addr_in = 5'd9;
        bus.w_data_in = 32'hABCD;
        tick();
        n_cmp++; if (bus.wr_commit !== 1'b0) begin n_err++; $display("FAIL rst_commit got %b exp 0", bus.wr_commit); end
        rst = 1'b0;
        idle();
        tick();
        n_cmp++; if (bus.r1_data !== 32'h0) begin n_err++; $display("FAIL rst_r9 got %h exp 0", bus.r1_data); end
        n_cmp++; if (bus.wr_count !== 4'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", bus.wr_count); end
    endtask
    initial begin
        test_reset();
        test_write();
        test_jal();
        test_r0();
        test_collision();
        test_back_to_back();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Register file sink for the writeback interface.
- Accepts the registered writeback bundle from the WB pipeline stage: write enable, write address, write data, jal flag and PC.
- Commits that bundle to the architectural registers.
- Serves two synchronous read ports to the decode stage. Also keeps a saturating count of committed writes for debug and performance visibility.

Parameters:
- DSIZE, 32, data/register width
- ASIZE, 5, register address width (2**ASIZE registers)
- ISIZE, 32, PC width
- LINK_REG, 31, destination register for jal link writes
- CNT_W, 16, width of the write-commit counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wen_in  in  1  writeback write enable
- w_addr_in  in  ASIZE  writeback destination register
- w_data_in  in  DSIZE  writeback data
- jal_in  in  1  writeback is a jal link write
- PC_in  in  ISIZE  PC of the writing instruction
- r1_addr  in  ASIZE  read port 1 address
- r2_addr  in  ASIZE  read port 2 address
- r1_data  out  DSIZE  read port 1 data, registered
- r2_data  out  DSIZE  read port 2 data, registered
- wr_commit  out  1  pulses for one cycle after a write to a nonzero register commits
- wr_count  out  CNT_W  saturating count of committed writes

Behaviour:
- Reset:
  - On posedge clk with rst=1: all 2**ASIZE registers := 0; r1_data, r2_data, wr_commit, wr_count := 0.
  - All write and read inputs are ignored that cycle.
  - Reset asserted while a write is presented drops the write; nothing is committed.
- Effective write, computed combinationally:
  - If jal_in=1 and wen_in=1: eff_addr=LINK_REG, eff_data=PC_in+1. The sum is computed at ISIZE width, wraps modulo 2**ISIZE, then is zero-extended or truncated to DSIZE.
  - Else if wen_in=1: eff_addr=w_addr_in, eff_data=w_data_in.
  - jal_in=1 with wen_in=0: no write.
- Commit:
  - At posedge clk (rst=0) with an effective write and eff_addr!=0: regs[eff_addr] := eff_data.
  - The same edge sets wr_commit := 1; otherwise wr_commit := 0.
- Register 0:
  - Always reads 0. Writes to it are discarded and do not assert wr_commit or increment wr_count.
- wr_count:
  - Increments by 1 on each commit.
  - Holds at 2**CNT_W-1 once reached, with no wrap.
- Reads:
  - At posedge clk (rst=0): rN_data := regs[rN_addr], or 0 if rN_addr=0.
  - Latency is 1 cycle; outputs hold between edges.
  - Both ports are independent and may use the same address.
- Read/write collision:
  - Occurs when rN_addr==eff_addr in the same cycle with a commit.
  - Behaviour depends on WB_BYPASS_EN; see Optional Feature.
- No back-pressure: one write and two reads are accepted every cycle.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: on a read/write collision, rN_data := eff_data at that edge (write-first). Decode sees the writeback value with no extra stall.
- Undefined: on a collision, rN_data := the pre-write register contents (read-first). The new value is visible from the next read.
- Register 0 reads 0 in both modes.

Decomposition:
- Shared package/include holds:
  - DSIZE, ASIZE, ISIZE defaults
  - LINK_REG constant
  - the PC-to-link-data increment constant (1)
- One natural sub-module, wb_write_select: the combinational effective-address/data/enable mux (jal vs normal, r0 squash).
- Storage, read ports and counter stay in the top module.

Test Plan:
- Reset then read: assert rst 1 cycle; r1_addr=5, r2_addr=31 -> next cycle r1_data=0, r2_data=0, wr_count=0, wr_commit=0.
- Normal write then read: wen_in=1, w_addr_in=3, w_data_in=0xDEADBEEF; next cycle r1_addr=3 -> one cycle later r1_data=0xDEADBEEF, wr_count=1, and wr_commit was 1 for exactly one cycle.
- jal link: wen_in=1, jal_in=1, PC_in=0x40, w_addr_in=7, w_data_in=0x1234 -> r31 reads 0x41, r7 unchanged (0). PC_in=0xFFFFFFFF -> r31 reads 0.
- r0 squash: wen_in=1, w_addr_in=0, w_data_in=0xFFFFFFFF -> r1_addr=0 reads 0; wr_commit stays 0; wr_count unchanged.
- Collision: r4 holds 0x11; same cycle wen_in=1, w_addr_in=4, w_data_in=0x22, r1_addr=r2_addr=4 -> with WB_BYPASS_EN both outputs=0x22; without it both=0x11, then 0x22 on the next read.
- Saturation and mid-run reset: CNT_W=4, 17 commits -> wr_count=15. Assert rst with wen_in=1, w_addr_in=9 -> r9=0 and wr_count=0 after reset.
